// File: rtl/pong_match_sequencer.sv
// pong_match_sequencer
// Two-player match controller for the LED ping-pong track. It sequences the
// serve, moves the ball along a one-hot LED track, decides hits and misses,
// shortens the step period as a rally goes on, keeps score and signals the
// end of the match. Everything runs in the slow game clock domain.
//
// Ports
//   slw_clk      game clock
//   Rst          asynchronous active-high reset
//   start_btn    start / restart match (debounced level, rise-detected)
//   p1_btn       player 1 paddle (debounced level, rise-detected)
//   p2_btn       player 2 paddle (debounced level, rise-detected)
//   abort_btn    level-sensitive soft abort back to IDLE
//   ball_pos     one-hot ball position, P1 end = MSB, P2 end = LSB
//   p1_score     player 1 points
//   p2_score     player 2 points
//   serve_owner  0 = P1 serves, 1 = P2 serves
//   rally_count  successful hits in the current rally (saturating)
//   match_over   high while in MATCH_END
//   winner       00 none, 01 P1, 10 P2
//   flash        toggles every cycle in POINT / MATCH_END, else 0
module pong_match_sequencer #(
  parameter int N_LEDS     = 4,
  parameter int BASE_DIV   = 4,
  parameter int MIN_DIV    = 1,
  parameter int WIN_SCORE  = 5,
  parameter int POINT_HOLD = 8
) (
  input  logic              slw_clk,
  input  logic              Rst,
  input  logic              start_btn,
  input  logic              p1_btn,
  input  logic              p2_btn,
  input  logic              abort_btn,
  output logic [N_LEDS-1:0] ball_pos,
  output logic [3:0]        p1_score,
  output logic [3:0]        p2_score,
  output logic              serve_owner,
  output logic [7:0]        rally_count,
  output logic              match_over,
  output logic [1:0]        winner,
  output logic              flash
);

  localparam int DIV_W  = $clog2(BASE_DIV + 1);
  localparam int HOLD_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;

  localparam logic [N_LEDS-1:0] P1_END    = {1'b1, {(N_LEDS-1){1'b0}}};
  localparam logic [N_LEDS-1:0] P2_END    = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]  DIV_BASE  = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(MIN_DIV);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POINT_HOLD - 1);
  localparam logic [3:0]        SCORE_WIN = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE      = 3'd1,
    S_MOVE_TO_P2 = 3'd2,
    S_MOVE_TO_P1 = 3'd3,
    S_POINT      = 3'd4,
    S_MATCH_END  = 3'd5
  } state_t;

  state_t            state;
  logic              start_prev;
  logic              p1_prev;
  logic              p2_prev;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  step_div;
  logic [HOLD_W-1:0] hold_cnt;
  logic              last_scorer;  // 0 = P1 scored last point, 1 = P2

  logic start_rise;
  logic p1_rise;
  logic p2_rise;
  logic step_expired;

  assign start_rise   = start_btn & ~start_prev;
  assign p1_rise      = p1_btn & ~p1_prev;
  assign p2_rise      = p2_btn & ~p2_prev;
  assign step_expired = (cnt == (step_div - DIV_W'(1)));

  function automatic logic [7:0] rally_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s >= SCORE_WIN) ? s : s + 4'd1;
  endfunction

  // Each hit shortens the step period by one, floored at MIN_DIV.
  function automatic logic [DIV_W-1:0] div_dec(input logic [DIV_W-1:0] d);
    return (d > DIV_MIN) ? d - DIV_W'(1) : DIV_MIN;
  endfunction

  always_ff @(posedge slw_clk or posedge Rst) begin
    if (Rst) begin
      state       <= S_IDLE;
      start_prev  <= 1'b0;
      p1_prev     <= 1'b0;
      p2_prev     <= 1'b0;
      cnt         <= '0;
      step_div    <= DIV_BASE;
      hold_cnt    <= '0;
      last_scorer <= 1'b0;
      ball_pos    <= '0;
      p1_score    <= '0;
      p2_score    <= '0;
      serve_owner <= 1'b0;
      rally_count <= '0;
      match_over  <= 1'b0;
      winner      <= '0;
      flash       <= 1'b0;
    end else begin
      start_prev <= start_btn;
      p1_prev    <= p1_btn;
      p2_prev    <= p2_btn;

      if (abort_btn) begin
        state       <= S_IDLE;
        ball_pos    <= '0;
        p1_score    <= '0;
        p2_score    <= '0;
        rally_count <= '0;
        winner      <= '0;
        match_over  <= 1'b0;
        flash       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            ball_pos <= '0;
            flash    <= 1'b0;
            if (start_rise) begin
              p1_score    <= '0;
              p2_score    <= '0;
              winner      <= '0;
              match_over  <= 1'b0;
              serve_owner <= 1'b0;
              ball_pos    <= P1_END;
              rally_count <= '0;
              cnt         <= '0;
              step_div    <= DIV_BASE;
              state       <= S_SERVE;
            end
          end

          S_SERVE: begin
            ball_pos    <= serve_owner ? P2_END : P1_END;
            cnt         <= '0;
            step_div    <= DIV_BASE;
            rally_count <= '0;
            if (!serve_owner && p1_rise) state <= S_MOVE_TO_P2;
            else if (serve_owner && p2_rise) state <= S_MOVE_TO_P1;
          end

          // A return at the paddle end beats an expiring step counter.
          S_MOVE_TO_P2: begin
            if (p2_rise && ball_pos[0]) begin
              state       <= S_MOVE_TO_P1;
              cnt         <= '0;
              step_div    <= div_dec(step_div);
              rally_count <= rally_inc(rally_count);
            end else if (step_expired) begin
              cnt <= '0;
              if (ball_pos[0]) begin
                p1_score    <= score_inc(p1_score);
                last_scorer <= 1'b0;
                ball_pos    <= '0;
                flash       <= 1'b1;
                hold_cnt    <= '0;
                state       <= S_POINT;
              end else begin
                ball_pos <= ball_pos >> 1;
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end

          S_MOVE_TO_P1: begin
            if (p1_rise && ball_pos[N_LEDS-1]) begin
              state       <= S_MOVE_TO_P2;
              cnt         <= '0;
              step_div    <= div_dec(step_div);
              rally_count <= rally_inc(rally_count);
            end else if (step_expired) begin
              cnt <= '0;
              if (ball_pos[N_LEDS-1]) begin
                p2_score    <= score_inc(p2_score);
                last_scorer <= 1'b1;
                ball_pos    <= '0;
                flash       <= 1'b1;
                hold_cnt    <= '0;
                state       <= S_POINT;
              end else begin
                ball_pos <= ball_pos << 1;
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end

          S_POINT: begin
            ball_pos <= '0;
            flash    <= ~flash;
            if (hold_cnt == HOLD_LAST) begin
              if ((last_scorer ? p2_score : p1_score) == SCORE_WIN) begin
                state      <= S_MATCH_END;
                match_over <= 1'b1;
                winner     <= last_scorer ? 2'b10 : 2'b01;
                flash      <= 1'b1;
                ball_pos   <= '1;
              end else begin
                // The new server is the opposite of the current owner.
                serve_owner <= ~serve_owner;
                ball_pos    <= serve_owner ? P1_END : P2_END;
                cnt         <= '0;
                step_div    <= DIV_BASE;
                rally_count <= '0;
                flash       <= 1'b0;
                state       <= S_SERVE;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end

          S_MATCH_END: begin
            flash    <= ~flash;
            // Track lights up whenever the new flash value is 1.
            ball_pos <= flash ? '0 : '1;
            if (start_rise) begin
              p1_score    <= '0;
              p2_score    <= '0;
              winner      <= '0;
              match_over  <= 1'b0;
              flash       <= 1'b0;
              serve_owner <= 1'b0;
              ball_pos    <= P1_END;
              rally_count <= '0;
              cnt         <= '0;
              step_div    <= DIV_BASE;
              state       <= S_SERVE;
            end
          end

          default: begin
            state      <= S_IDLE;
            ball_pos   <= '0;
            flash      <= 1'b0;
            match_over <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed testbench for pong_match_sequencer (default parameters).
module tb_pong_match_sequencer;

  logic       slw_clk = 1'b0;
  logic       Rst;
  logic       start_btn;
  logic       p1_btn;
  logic       p2_btn;
  logic       abort_btn;
  logic [3:0] ball_pos;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       serve_owner;
  logic [7:0] rally_count;
  logic       match_over;
  logic [1:0] winner;
  logic       flash;

  int tests = 0;
  int fails = 0;

  always #5 slw_clk = ~slw_clk;

  pong_match_sequencer #(
    .N_LEDS(4), .BASE_DIV(4), .MIN_DIV(1), .WIN_SCORE(5), .POINT_HOLD(8)
  ) dut (
    .slw_clk    (slw_clk),
    .Rst        (Rst),
    .start_btn  (start_btn),
    .p1_btn     (p1_btn),
    .p2_btn     (p2_btn),
    .abort_btn  (abort_btn),
    .ball_pos   (ball_pos),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .serve_owner(serve_owner),
    .rally_count(rally_count),
    .match_over (match_over),
    .winner     (winner),
    .flash      (flash)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge slw_clk);
      #1;
    end
  endtask

  task automatic press_p1();
    p1_btn = 1'b1;
    cyc(1);
    p1_btn = 1'b0;
  endtask

  task automatic press_p2();
    p2_btn = 1'b1;
    cyc(1);
    p2_btn = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ball"},   32'(ball_pos),    32'h0);
    chk({tag, "_p1"},     32'(p1_score),    32'h0);
    chk({tag, "_p2"},     32'(p2_score),    32'h0);
    chk({tag, "_owner"},  32'(serve_owner), 32'h0);
    chk({tag, "_rally"},  32'(rally_count), 32'h0);
    chk({tag, "_over"},   32'(match_over),  32'h0);
    chk({tag, "_winner"}, 32'(winner),      32'h0);
    chk({tag, "_flash"},  32'(flash),       32'h0);
  endtask

  initial begin
    logic exp_own;
    Rst = 1'b1; start_btn = 1'b0; p1_btn = 1'b0; p2_btn = 1'b0; abort_btn = 1'b0;
    cyc(2);
    chk_all_zero("reset");
    Rst = 1'b0;
    cyc(1);
    chk("idle_ball", 32'(ball_pos), 32'h0);

    // Start: P1 serves from MSB; holding start does nothing more.
    start_btn = 1'b1;
    cyc(1);
    chk("serve_ball", 32'(ball_pos), 32'h8);
    chk("serve_owner", 32'(serve_owner), 32'h0);
    cyc(1);
    start_btn = 1'b0;
    chk("serve_held_start", 32'(ball_pos), 32'h8);
    p2_btn = 1'b1;
    cyc(1);
    p2_btn = 1'b0;
    cyc(3);
    chk("serve_nonserver_ignored", 32'(ball_pos), 32'h8);

    // Unreturned serve: 4 cycles per LED, then P1 scores.
    press_p1();
    cyc(3);
    chk("move_1000_hold", 32'(ball_pos), 32'h8);
    cyc(1);
    chk("move_0100", 32'(ball_pos), 32'h4);
    cyc(4);
    chk("move_0010", 32'(ball_pos), 32'h2);
    cyc(4);
    chk("move_0001", 32'(ball_pos), 32'h1);
    cyc(3);
    chk("move_0001_last", 32'(ball_pos), 32'h1);
    chk("no_score_yet", 32'(p1_score), 32'h0);
    cyc(1);
    chk("point_ball", 32'(ball_pos), 32'h0);
    chk("point_p1", 32'(p1_score), 32'h1);
    chk("point_flash0", 32'(flash), 32'h1);
    cyc(1);
    chk("point_flash1", 32'(flash), 32'h0);
    cyc(6);
    chk("point_flash7", 32'(flash), 32'h0);
    chk("point_still_ball", 32'(ball_pos), 32'h0);
    cyc(1);
    chk("p2serve_owner", 32'(serve_owner), 32'h1);
    chk("p2serve_ball", 32'(ball_pos), 32'h1);
    chk("p2serve_flash", 32'(flash), 32'h0);

    // P2 serve travels left, then abort mid-flight.
    press_p2();
    cyc(4);
    chk("p2serve_0010", 32'(ball_pos), 32'h2);
    abort_btn = 1'b1;
    cyc(1);
    abort_btn = 1'b0;
    chk("abort_ball", 32'(ball_pos), 32'h0);
    chk("abort_p1", 32'(p1_score), 32'h0);
    cyc(2);
    chk("abort_idle", 32'(ball_pos), 32'h0);

    // Rally with speed-up.
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    chk("restart_ball", 32'(ball_pos), 32'h8);
    chk("restart_owner", 32'(serve_owner), 32'h0);
    press_p1();
    cyc(12);
    chk("rally_at_lsb", 32'(ball_pos), 32'h1);
    press_p2();
    chk("hit1_ball", 32'(ball_pos), 32'h1);
    chk("hit1_rally", 32'(rally_count), 32'h1);
    cyc(2);
    chk("div3_hold", 32'(ball_pos), 32'h1);
    cyc(1);
    chk("div3_step", 32'(ball_pos), 32'h2);
    cyc(3);
    chk("div3_0100", 32'(ball_pos), 32'h4);
    cyc(3);
    chk("div3_1000", 32'(ball_pos), 32'h8);
    press_p1();
    chk("hit2_rally", 32'(rally_count), 32'h2);
    cyc(1);
    chk("div2_hold", 32'(ball_pos), 32'h8);
    cyc(1);
    chk("div2_step", 32'(ball_pos), 32'h4);
    p2_btn = 1'b1;
    cyc(1);
    p2_btn = 1'b0;
    chk("early_p2_ignored_ball", 32'(ball_pos), 32'h4);
    chk("early_p2_ignored_rally", 32'(rally_count), 32'h2);
    cyc(1);
    chk("div2_0010", 32'(ball_pos), 32'h2);
    cyc(2);
    chk("div2_0001", 32'(ball_pos), 32'h1);
    p1_btn = 1'b1; p2_btn = 1'b1;
    cyc(1);
    p1_btn = 1'b0; p2_btn = 1'b0;
    chk("both_hit_ball", 32'(ball_pos), 32'h1);
    chk("both_hit_rally", 32'(rally_count), 32'h3);
    cyc(1);
    chk("div1_step", 32'(ball_pos), 32'h2);
    cyc(2);
    chk("div1_1000", 32'(ball_pos), 32'h8);
    press_p1();
    chk("expire_hit_p1_ball", 32'(ball_pos), 32'h8);
    chk("expire_hit_p1_rally", 32'(rally_count), 32'h4);
    chk("expire_hit_p1_noscore", 32'(p2_score), 32'h0);
    cyc(1);
    chk("floor_step", 32'(ball_pos), 32'h4);
    cyc(2);
    chk("floor_0001", 32'(ball_pos), 32'h1);
    press_p2();
    chk("expire_hit_p2_ball", 32'(ball_pos), 32'h1);
    chk("expire_hit_p2_rally", 32'(rally_count), 32'h5);
    chk("expire_hit_p2_noscore", 32'(p1_score), 32'h0);
    cyc(3);
    chk("floor_back_1000", 32'(ball_pos), 32'h8);
    cyc(1);
    chk("p2_point_ball", 32'(ball_pos), 32'h0);
    chk("p2_point_score", 32'(p2_score), 32'h1);
    chk("p2_point_flash", 32'(flash), 32'h1);
    cyc(8);
    chk("after_p2_point_owner", 32'(serve_owner), 32'h1);
    chk("after_p2_point_ball", 32'(ball_pos), 32'h1);
    chk("after_p2_point_rally", 32'(rally_count), 32'h0);

    // Fresh match; P1 takes five straight points.
    abort_btn = 1'b1;
    cyc(1);
    abort_btn = 1'b0;
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_own = ((k - 1) % 2) != 0;
      chk($sformatf("match_owner_%0d", k), 32'(serve_owner), 32'(exp_own));
      chk($sformatf("match_serve_ball_%0d", k), 32'(ball_pos), exp_own ? 32'h1 : 32'h8);
      if (!exp_own) begin
        press_p1();
        cyc(16);
      end else begin
        press_p2();
        cyc(12);
        press_p1();
        cyc(12);
      end
      chk($sformatf("match_p1_%0d", k), 32'(p1_score), 32'(k));
      chk($sformatf("match_p2_%0d", k), 32'(p2_score), 32'h0);
      cyc(8);
    end
    chk("end_over", 32'(match_over), 32'h1);
    chk("end_winner", 32'(winner), 32'h1);
    chk("end_ball_on", 32'(ball_pos), 32'hF);
    chk("end_flash_on", 32'(flash), 32'h1);
    cyc(1);
    chk("end_ball_off", 32'(ball_pos), 32'h0);
    chk("end_flash_off", 32'(flash), 32'h0);
    cyc(1);
    chk("end_ball_on2", 32'(ball_pos), 32'hF);
    chk("end_score_capped", 32'(p1_score), 32'h5);

    abort_btn = 1'b1;
    cyc(1);
    abort_btn = 1'b0;
    chk("end_abort_over", 32'(match_over), 32'h0);
    chk("end_abort_winner", 32'(winner), 32'h0);
    chk("end_abort_p1", 32'(p1_score), 32'h0);
    chk("end_abort_ball", 32'(ball_pos), 32'h0);
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    chk("new_match_ball", 32'(ball_pos), 32'h8);
    chk("new_match_owner", 32'(serve_owner), 32'h0);

    // Asynchronous reset in the middle of a rally.
    press_p1();
    cyc(5);
    chk("pre_rst_ball", 32'(ball_pos), 32'h4);
    #2;
    Rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    cyc(1);
    Rst = 1'b0;
    cyc(2);
    chk("post_rst_ball", 32'(ball_pos), 32'h0);
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    chk("post_rst_start", 32'(ball_pos), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pong_match_sequencer.md
Name: pong_match_sequencer

Overview:
- Two-player match controller for the LED ping-pong track.
- Sequences serves, ball travel, hit/miss arbitration between two players sharing one LED track, rally speed-up, scoring and end-of-match signalling.
- Sits between the debounced button inputs and the LED/score display drivers.
- Runs entirely in the slow game clock domain.

Parameters:
N_LEDS, 4, track length; ball_pos is one-hot across N_LEDS bits; P1 end = MSB, P2 end = LSB
BASE_DIV, 4, slw_clk cycles per ball step at serve (≥1)
MIN_DIV, 1, fastest step period after speed-ups (1..BASE_DIV)
WIN_SCORE, 5, points needed to win the match (1..15)
POINT_HOLD, 8, cycles spent in POINT display before next serve

Ports:
slw_clk  in  1  game clock
Rst  in  1  reset, asynchronous, active-high
start_btn  in  1  start/restart match (level, debounced, synchronous)
p1_btn  in  1  player 1 paddle (level, debounced)
p2_btn  in  1  player 2 paddle (level, debounced)
abort_btn  in  1  synchronous soft abort to IDLE
ball_pos  out  N_LEDS  one-hot ball position, 0 when no ball
p1_score  out  4  player 1 points
p2_score  out  4  player 2 points
serve_owner  out  1  0 = P1 serves, 1 = P2 serves
rally_count  out  8  successful hits in current rally, saturates at 255
match_over  out  1  high in MATCH_END
winner  out  2  00 none, 01 P1, 10 P2
flash  out  1  toggles every cycle in POINT/MATCH_END, else 0

Behaviour:
- Reset: Rst=1 forces IDLE. All outputs 0. Button history registers 0. Step counter 0. step_div = BASE_DIV.
- Edge detection: every button has a registered previous value. A rise is btn=1 at a clock edge with previous=0. Response is visible on outputs after that same edge. Held buttons produce one rise only.
- abort_btn=1 at any edge has top priority:
  - next state IDLE;
  - scores, rally_count, winner cleared;
  - ball_pos=0.
- IDLE: ball_pos=0. A start_btn rise clears scores and winner, sets serve_owner=0, and goes to SERVE.
- SERVE:
  - ball_pos = server's end bit (P1: MSB, P2: LSB).
  - step_div=BASE_DIV, cnt=0, rally_count=0.
  - A rise on the server's button goes to MOVE_TO_P2 (P1 served) or MOVE_TO_P1 (P2 served).
  - The non-server's button is ignored.
- MOVE_TO_P2:
  - cnt increments every cycle. When cnt == step_div-1: cnt←0, and if ball_pos[0]=0 then ball_pos shifts right by one.
  - If cnt == step_div-1 and ball_pos[0]=1: miss; P1 scores; go to POINT.
  - A p2_btn rise while ball_pos[0]=1 (including the cycle cnt expires) is a hit, and the hit wins over the miss:
    - state→MOVE_TO_P1, cnt←0;
    - step_div←max(step_div-1, MIN_DIV);
    - rally_count+1 (saturating);
    - ball stays at LSB until the next step.
  - p1_btn and p2_btn rises while the ball is not at P2's end are ignored.
- MOVE_TO_P1: mirror of MOVE_TO_P2 (left shift, MSB, p1_btn, P2 scores on miss).
- Simultaneous p1/p2 rises: only the player at whose end the ball sits is considered.
- POINT:
  - ball_pos=0; flash toggles each cycle starting at 1; counts POINT_HOLD cycles.
  - On exit: if the scorer's score == WIN_SCORE, go to MATCH_END; else serve_owner toggles and go to SERVE.
- MATCH_END:
  - match_over=1; winner set to the scorer.
  - flash toggles each cycle; ball_pos = all ones when flash=1, else 0.
  - A start_btn rise starts a new match as from IDLE.
- Score registers are 4-bit and increment only on a miss. They cannot exceed WIN_SCORE.
- Unused state encodings → IDLE.

Test Plan:
- Defaults; Rst pulse mid-MOVE → all outputs 0 immediately (async), state IDLE, ball_pos=0 after release.
- start rise, p1 rise, no p2 → ball 1000→0100→0010→0001 every 4 cycles; 4 cycles at 0001 → p1_score=1, POINT 8 cycles with flash toggling, then SERVE with serve_owner=1 and ball_pos=0001.
- P1 serves, p2 rise while ball_pos=0001 → direction reverses, rally_count=1, next step after 3 cycles. Further hits → periods 2 then 1, floor at 1 (MIN_DIV).
- p1 and p2 rise together while ball at 0001 → treated as P2 hit only. p2 rise while ball at 0100 → ignored, ball continues.
- p2 rise on the exact cycle cnt expires at LSB → hit, no score change.
- P1 wins 5 points → match_over=1, winner=01, ball_pos alternates 1111/0000. abort_btn → IDLE with scores 0. start rise → new match.
